// File: rtl/nn_run_sequencer.sv
// Run sequencer: streams one feature sample into classifier X0, starts it, returns the result.
// Optional watchdog on the classifier wait is enabled by defining NN_SEQ_WATCHDOG_EN.
module nn_run_sequencer #(
  parameter int         DW        = 16,
  parameter int         N_FEAT    = 7,
  parameter logic [3:0] ANOM_MASK = 4'b1110,
  parameter int         TIMEOUT   = 4096
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          feat_valid,
  output logic          feat_ready,
  input  logic [DW-1:0] feat_data,
  output logic          nn_x0_wr_en,
  output logic [2:0]    nn_x0_wr_addr,
  output logic [DW-1:0] nn_x0_wr_data,
  output logic          nn_start,
  input  logic          nn_done,
  input  logic [1:0]    nn_class,
  input  logic [DW-1:0] nn_score,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [1:0]    res_class,
  output logic [DW-1:0] res_score,
  output logic          res_anomaly,
  output logic          busy,
  output logic          timeout_err,
  input  logic          err_clr
);

  typedef enum logic [2:0] {
    IDLE, LOAD, START, WAIT, RESULT
  } state_t;

  state_t     state, state_nx;
  logic [2:0] beat;
  logic       accept;
  logic       last_beat;
  logic       expire;
  logic       res_take;

  assign feat_ready = (state == LOAD);
  assign busy       = (state != IDLE);
  assign accept     = feat_valid && feat_ready;
  assign last_beat  = (beat == 3'(N_FEAT - 1));
  assign res_take   = res_valid && res_ready;

`ifdef NN_SEQ_WATCHDOG_EN
  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [WW-1:0] wdog;

  // done on the expiry cycle takes precedence over the timeout
  assign expire = (state == WAIT) && !nn_done &&
                  (wdog == WW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog <= '0;
    end else if (state == WAIT && !nn_done && !expire) begin
      wdog <= wdog + 1'b1;
    end else begin
      wdog <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_err <= 1'b0;
    end else if (expire) begin
      timeout_err <= 1'b1;
    end else if (err_clr) begin
      timeout_err <= 1'b0;
    end
  end
`else
  logic unused_err_clr;

  assign expire         = 1'b0;
  assign timeout_err    = 1'b0;
  assign unused_err_clr = err_clr;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (en) state_nx = LOAD;
      end
      LOAD: begin
        // an accepted beat always wins; only an empty sample may be abandoned
        if (accept && last_beat) begin
          state_nx = START;
        end else if (!accept && beat == 3'd0 && !en) begin
          state_nx = IDLE;
        end
      end
      START: begin
        state_nx = WAIT;
      end
      WAIT: begin
        if (nn_done) begin
          state_nx = RESULT;
        end else if (expire) begin
          state_nx = en ? LOAD : IDLE;
        end
      end
      RESULT: begin
        if (res_take) state_nx = en ? LOAD : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat <= 3'd0;
    end else if (accept) begin
      beat <= last_beat ? 3'd0 : beat + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nn_x0_wr_en   <= 1'b0;
      nn_x0_wr_addr <= 3'd0;
      nn_x0_wr_data <= '0;
      nn_start      <= 1'b0;
    end else begin
      nn_x0_wr_en <= accept;
      nn_start    <= (state == START);
      if (accept) begin
        nn_x0_wr_addr <= beat;
        nn_x0_wr_data <= feat_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid   <= 1'b0;
      res_class   <= 2'd0;
      res_score   <= '0;
      res_anomaly <= 1'b0;
    end else if (state == WAIT && nn_done) begin
      res_valid   <= 1'b1;
      res_class   <= nn_class;
      res_score   <= nn_score;
      res_anomaly <= ANOM_MASK[nn_class];
    end else if (res_take) begin
      res_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nn_run_sequencer.sv
// Randomized sample-level bench for nn_run_sequencer; expectations come from protocol timing.
// Works in both builds (NN_SEQ_WATCHDOG_EN defined or not).
module tb_nn_run_sequencer;

  localparam int DW  = 16;
  localparam int NF  = 7;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          feat_valid;
  logic          feat_ready;
  logic [DW-1:0] feat_data;
  logic          nn_x0_wr_en;
  logic [2:0]    nn_x0_wr_addr;
  logic [DW-1:0] nn_x0_wr_data;
  logic          nn_start;
  logic          nn_done;
  logic [1:0]    nn_class;
  logic [DW-1:0] nn_score;
  logic          res_valid;
  logic          res_ready;
  logic [1:0]    res_class;
  logic [DW-1:0] res_score;
  logic          res_anomaly;
  logic          busy;
  logic          timeout_err;
  logic          err_clr;

  int n_chk = 0;
  int n_err = 0;
  logic [3:0] anom_tbl = 4'b1110;

  nn_run_sequencer #(
    .DW(DW), .N_FEAT(NF), .ANOM_MASK(4'b1110), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .feat_valid(feat_valid), .feat_ready(feat_ready),
    .feat_data(feat_data),
    .nn_x0_wr_en(nn_x0_wr_en), .nn_x0_wr_addr(nn_x0_wr_addr),
    .nn_x0_wr_data(nn_x0_wr_data), .nn_start(nn_start),
    .nn_done(nn_done), .nn_class(nn_class), .nn_score(nn_score),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_class(res_class), .res_score(res_score),
    .res_anomaly(res_anomaly), .busy(busy),
    .timeout_err(timeout_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_time_limit got=running want=finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, 32'(feat_ready), 0);
    chk({tag, "_wr_en"}, 32'(nn_x0_wr_en), 0);
    chk({tag, "_wr_addr"}, 32'(nn_x0_wr_addr), 0);
    chk({tag, "_wr_data"}, 32'(nn_x0_wr_data), 0);
    chk({tag, "_start"}, 32'(nn_start), 0);
    chk({tag, "_res_valid"}, 32'(res_valid), 0);
    chk({tag, "_res_class"}, 32'(res_class), 0);
    chk({tag, "_res_score"}, 32'(res_score), 0);
    chk({tag, "_res_anom"}, 32'(res_anomaly), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_to_err"}, 32'(timeout_err), 0);
  endtask

  // Enter with feat_ready=1 at a falling edge; leave after the result
  // handshake (or the timeout) at a falling edge.
  task automatic run_sample(input int lat, input int rdly,
                            input bit drop_en, input bit to_case,
                            input bit directed, input int cls_i,
                            input int scr_i);
    logic [DW-1:0] f [NF];
    logic [1:0]    cls;
    logic [DW-1:0] scr;
    int            gap;
    int            wl;
    cls = 2'(cls_i);
    scr = DW'(scr_i);
    for (int k = 0; k < NF; k++)
      f[k] = directed ? DW'(k + 1) : DW'($urandom);
    for (int k = 0; k < NF; k++) begin
      gap = (!directed && $urandom_range(0, 3) == 0) ?
            int'($urandom_range(1, 2)) : 0;
      for (int g = 0; g < gap; g++) begin
        feat_valid = 1'b0;
        feat_data  = DW'($urandom);
        tick();
        chk("gap_wr_en", 32'(nn_x0_wr_en), 0);
        chk("gap_ready", 32'(feat_ready), 1);
      end
      if (drop_en && k == 3) en = 1'b0;
      feat_valid = 1'b1;
      feat_data  = f[k];
      tick();
      chk("wr_en", 32'(nn_x0_wr_en), 1);
      chk("wr_addr", 32'(nn_x0_wr_addr), k);
      chk("wr_data", 32'(nn_x0_wr_data), 32'(f[k]));
      chk("start_early", 32'(nn_start), 0);
    end
    feat_valid = 1'b0;
    chk("start_cyc_ready", 32'(feat_ready), 0);
    tick();
    chk("nn_start", 32'(nn_start), 1);
    chk("wr_after_last", 32'(nn_x0_wr_en), 0);
    wl = lat;
    if (to_case) begin
`ifdef NN_SEQ_WATCHDOG_EN
      for (int j = 0; j < TMO; j++) begin
        chk("wd_ready", 32'(feat_ready), 0);
        chk("wd_err_low", 32'(timeout_err), 0);
        err_clr = (j == TMO - 1);
        tick();
        chk("wd_start_once", 32'(nn_start), 0);
      end
      err_clr = 1'b0;
      chk("to_err_set", 32'(timeout_err), 1);
      chk("to_ready", 32'(feat_ready), 32'(en));
      chk("to_busy", 32'(busy), 32'(en));
      chk("to_res_valid", 32'(res_valid), 0);
      nn_done = 1'b1;
      tick();
      nn_done = 1'b0;
      chk("stray_res_valid", 32'(res_valid), 0);
      chk("stray_err_held", 32'(timeout_err), 1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("err_clr", 32'(timeout_err), 0);
      chk("after_to_res", 32'(res_valid), 0);
      return;
`else
      wl = TMO + 4;
`endif
    end
    for (int j = 0; j < wl; j++) begin
      chk("wait_ready", 32'(feat_ready), 0);
      chk("wait_res_valid", 32'(res_valid), 0);
      chk("wait_err", 32'(timeout_err), 0);
      nn_class = 2'($urandom);
      nn_score = DW'($urandom);
      tick();
      chk("wait_start_once", 32'(nn_start), 0);
    end
    nn_done  = 1'b1;
    nn_class = cls;
    nn_score = scr;
    tick();
    nn_done  = 1'($urandom_range(0, 1));
    nn_class = ~cls;
    nn_score = ~scr;
    chk("res_valid", 32'(res_valid), 1);
    chk("res_class", 32'(res_class), 32'(cls));
    chk("res_score", 32'(res_score), 32'(scr));
    chk("res_anomaly", 32'(res_anomaly), 32'(anom_tbl[cls]));
    chk("res_ready_low", 32'(feat_ready), 0);
    for (int i = 0; i < rdly; i++) begin
      res_ready = 1'b0;
      tick();
      chk("hold_valid", 32'(res_valid), 1);
      chk("hold_class", 32'(res_class), 32'(cls));
      chk("hold_score", 32'(res_score), 32'(scr));
      chk("hold_anom", 32'(res_anomaly), 32'(anom_tbl[cls]));
      chk("hold_ready", 32'(feat_ready), 0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    nn_done   = 1'b0;
    chk("res_drop", 32'(res_valid), 0);
    chk("post_ready", 32'(feat_ready), 32'(en));
    chk("post_busy", 32'(busy), 32'(en));
    chk("no_to_err", 32'(timeout_err), 0);
  endtask

  task automatic rearm();
    if (!en) begin
      en = 1'b1;
      tick();
    end
    chk("rearm_ready", 32'(feat_ready), 1);
  endtask

  initial begin
    int lat_max;
    rst = 1'b1; en = 1'b0; feat_valid = 1'b0; feat_data = '0;
    nn_done = 1'b0; nn_class = '0; nn_score = '0;
    res_ready = 1'b0; err_clr = 1'b0;
    tick();
    tick();
    chk_reset("reset");
    rst = 1'b0;
    tick();
    chk("idle_en0", 32'(busy), 0);
    en = 1'b1;
    tick();
    chk("load_ready", 32'(feat_ready), 1);

    run_sample(3, 0, 1'b0, 1'b0, 1'b1, 2, 'h0123);
    run_sample(2, 10, 1'b0, 1'b0, 1'b0, 0, int'($urandom));
    run_sample(TMO - 1, 1, 1'b0, 1'b0, 1'b0, 3, int'($urandom));
    run_sample(0, 0, 1'b0, 1'b1, 1'b0, 1, int'($urandom));
    rearm();
    run_sample(4, 2, 1'b1, 1'b0, 1'b0, 1, int'($urandom));
    chk("drop_idle_busy", 32'(busy), 0);
    rearm();
    en = 1'b0;
    tick();
    chk("empty_load_exit", 32'(busy), 0);
    rearm();

`ifdef NN_SEQ_WATCHDOG_EN
    lat_max = TMO - 1;
`else
    lat_max = 25;
`endif
    for (int s = 0; s < 24; s++) begin
      run_sample(int'($urandom_range(0, lat_max)),
                 int'($urandom_range(0, 5)),
                 1'($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 7) == 0),
                 1'b0, int'($urandom_range(0, 3)), int'($urandom));
      rearm();
    end

    feat_valid = 1'b1;
    for (int k = 0; k < NF; k++) begin
      feat_data = DW'(k);
      tick();
    end
    feat_valid = 1'b0;
    tick();
    chk("rst_pre_start", 32'(nn_start), 1);
    tick();
    tick();
    en  = 1'b0;
    rst = 1'b1;
    #1;
    chk_reset("rst_wait");
    tick();
    rst     = 1'b0;
    nn_done = 1'b1;
    tick();
    nn_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("late_done_valid", 32'(res_valid), 0);
      chk("late_done_start", 32'(nn_start), 0);
      chk("late_done_busy", 32'(busy), 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/nn_run_sequencer.md
# nn_run_sequencer

Run sequencer for the three-layer 7→32→16→4 anomaly classifier. It accepts a 7-feature sample from the sensor front end over a valid/ready stream and writes it into the classifier's X0 input RAM through the host write port. It then pulses the classifier start, waits for done with an optional watchdog, and returns class/score plus an anomaly flag over a valid/ready result channel. The block sits between the sensor/feature pipeline and the classifier top, and is the only driver of the classifier's host-side pins.

## Interface
- DW, 16, feature/score width (signed)
- N_FEAT, 7, features per sample; X0 address range 0..N_FEAT-1
- ANOM_MASK, 4'b1110, bit i set ⇒ class i is flagged anomalous
- TIMEOUT, 4096, watchdog limit in clk cycles (WAIT state only)
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  run enable; low parks the block in IDLE between samples
- feat_valid  in  1  feature beat valid
- feat_ready  out  1  feature beat accepted when valid&&ready
- feat_data  in  DW  signed feature; beats arrive in address order 0..N_FEAT-1
- nn_x0_wr_en  out  1  X0 write strobe (registered)
- nn_x0_wr_addr  out  3  X0 write address
- nn_x0_wr_data  out  DW  X0 write data
- nn_start  out  1  one-cycle classifier start pulse
- nn_done  in  1  classifier done (pulse or level)
- nn_class  in  2  classifier argmax index
- nn_score  in  DW  classifier max score (signed)
- res_valid  out  1  result valid; held until res_ready
- res_ready  in  1  result consumer ready
- res_class  out  2  captured class
- res_score  out  DW  captured score
- res_anomaly  out  1  ANOM_MASK[res_class]
- busy  out  1  state != IDLE
- timeout_err  out  1  sticky watchdog flag
- err_clr  in  1  clears timeout_err

## Operation
- States: IDLE, LOAD, START, WAIT, RESULT.
- IDLE: feat_ready=0. Moves to LOAD when en=1.
- LOAD: feat_ready=1. Each accepted beat writes X0 at beat index k (0..N_FEAT-1). A 3-bit beat counter increments per accept. After beat N_FEAT-1 is accepted, the counter clears and the state moves to START.
  - If en=0 while k=0, return to IDLE.
  - Once k>0, the sample is always completed.
- START: single cycle; schedules nn_start. Then WAIT.
- WAIT: the watchdog counter runs from 0.
  - nn_done=1 captures nn_class and nn_score into the res_* registers, then moves to RESULT.
  - If the counter reaches TIMEOUT-1 without done: set timeout_err, discard the sample, move to LOAD (or IDLE if en=0).
  - If nn_done and expiry coincide, done wins.
- RESULT: res_valid=1. On res_valid&&res_ready, res_valid drops and the state moves to LOAD (en=1) or IDLE (en=0).
- nn_done outside WAIT is ignored.
- res_anomaly = ANOM_MASK[captured class]. It is computed at capture and held with res_class.
- err_clr clears timeout_err. If err_clr and a new timeout occur in the same cycle, set wins.
- The block never resets the classifier. After rst, a late nn_done is ignored because the state is IDLE.

## Timing
- Reset values:
  - state=IDLE
  - feat_ready=0, nn_x0_wr_en=0, nn_x0_wr_addr=0, nn_x0_wr_data=0, nn_start=0
  - res_valid=0, res_class=0, res_score=0, res_anomaly=0
  - busy=0, timeout_err=0
  - counters=0
- feat_ready is a decode of state (combinational). All nn_* and res_* outputs are registered.
- A beat accepted at edge T drives nn_x0_wr_en/addr/data high during cycle T+1, for one cycle per beat.
- With the last beat accepted at edge T:
  - START occupies cycle T+1.
  - nn_start is high during cycle T+2 only.
  - WAIT begins at cycle T+2.
- nn_done sampled high at edge D ⇒ res_valid high from cycle D+1.
- Back-to-back throughput: N_FEAT + 2 + classifier latency + 1 + result-handshake cycles per sample.
- Asynchronous rst mid-LOAD/WAIT/RESULT: all outputs take reset values immediately. The partial sample is lost.

## Configuration
- NN_SEQ_WATCHDOG_EN defined: the TIMEOUT counter and timeout_err are active as described above.
- Not defined: no watchdog counter. WAIT exits only on nn_done. timeout_err is tied 0 and err_clr is ignored.

## Test plan
- Reset, en=1, stream features 1..7 with feat_valid held high → 7 X0 writes at addr 0..6 on consecutive cycles, data 1..7; nn_start one pulse two cycles after the 7th accept.
- nn_done with nn_class=2, nn_score=0x0123, res_ready=1 → res_valid one cycle, res_class=2, res_score=0x0123, res_anomaly=1; back to LOAD with feat_ready=1.
- nn_class=0, res_ready held low 10 cycles → res_valid held steady 10 cycles, res_anomaly=0, feat_ready=0 throughout.
- Watchdog build, TIMEOUT=16, no nn_done → timeout_err=1 after 16 WAIT cycles, state LOAD, no res_valid. A later stray nn_done is ignored. err_clr clears the flag.
- en dropped after beat 3 → remaining 4 beats still accepted, inference completes, then IDLE with busy=0.
- rst asserted during WAIT, then nn_done pulsed → all outputs at reset values, no res_valid, no nn_start.
